cnn_infer_seq: RTL and testbench
================================

CNN_INFER_SEQ -- requirements
Module: cnn_infer_seq

Interface
REQ-001 SHALL have parameters: IMG_PIXELS, default 784, pixels per image; ADDR_W, default 20, pixel-memory address width; IDX_W, default 10, image index/count width; CNT_W, default 32, latency counter width; TIMEOUT, default 65535, max WAIT_DONE cycles; GAP, default 4, idle cycles between images.
REQ-002 SHALL have ports: clk in 1, single clock, rising edge; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start in 1, 1-cycle batch start pulse; abort in 1, synchronous batch cancel; num_images in IDX_W, images in batch, sampled at start.
REQ-004 SHALL have ports: busy out 1, batch in progress; done out 1, 1-cycle batch-complete pulse.
REQ-005 SHALL have ports: mem_rd_en out 1, pixel read strobe; mem_addr out ADDR_W, pixel address; mem_rd_data in 8, pixel byte, valid exactly 1 cycle after mem_rd_en.
REQ-006 SHALL have ports: cnn_valid_in out 1, pixel beat to CNN top; cnn_data_in out 8 signed, pixel value; cnn_fc_done in 1, CNN inference finished; cnn_final_digit in 4, CNN class.
REQ-007 SHALL have ports: res_valid out 1, 1-cycle result pulse; res_index out IDX_W, image number; res_digit out 4, class or 4'hF on timeout; res_cycles out CNT_W, measured latency; res_timeout out 1, result is a timeout.

Function
REQ-008 SHALL implement states IDLE, PRIME, STREAM, WAIT_DONE, REPORT, GAP_WAIT.
REQ-009 SHALL leave IDLE only on start while busy=0; start while busy=1 SHALL be ignored.
REQ-010 SHALL, on start with num_images=0, pulse done the next cycle, remain IDLE, and issue no memory reads or CNN beats.
REQ-011 SHALL, in PRIME, issue mem_rd_en for address img*IMG_PIXELS (1 cycle), then enter STREAM.
REQ-012 SHALL, in STREAM, keep mem_rd_en high for consecutive addresses and drive cnn_valid_in=1 with cnn_data_in=mem_rd_data for exactly IMG_PIXELS contiguous cycles, no bubbles.
REQ-013 SHALL drop cnn_valid_in and force cnn_data_in=0 in the cycle after the last pixel beat and enter WAIT_DONE.
REQ-014 SHALL set latency counter to 0 on the first pixel beat and increment every cycle; res_cycles SHALL equal the counter value in the cycle cnn_fc_done is sampled high (first beat at cycle T, fc_done at T+N -> N).
REQ-015 SHALL, in WAIT_DONE on cnn_fc_done=1, latch cnn_final_digit and enter REPORT.
REQ-016 SHALL, if WAIT_DONE lasts TIMEOUT cycles without fc_done, report res_digit=4'hF, res_timeout=1, res_cycles=counter value, and continue the batch.
REQ-017 SHALL ignore cnn_fc_done outside WAIT_DONE.
REQ-018 SHALL, in REPORT, pulse res_valid for 1 cycle with res_index = 0-based image number; res_* SHALL hold until the next report.
REQ-019 SHALL, after REPORT, wait GAP cycles in GAP_WAIT, then go to PRIME for the next image, or pulse done and go IDLE after the last image.
REQ-020 SHALL compute addresses as img*IMG_PIXELS+pixel in ADDR_W bits with a running adder (no multiplier); 1000 images must fit in 20 bits.
REQ-021 SHALL, on abort in any non-IDLE state, deassert cnn_valid_in and mem_rd_en the next cycle, emit no res_valid and no done, and return to IDLE; abort takes priority over a simultaneous fc_done.
REQ-022 SHALL saturate the latency counter at all-ones rather than wrap.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously enter IDLE and clear busy, done, mem_rd_en, mem_addr, cnn_valid_in, cnn_data_in, res_valid, res_index, res_digit, res_cycles, res_timeout, and the latency counter.
REQ-024 SHALL, on reset mid-STREAM, drop cnn_valid_in immediately; no partial result is produced.

Structure
REQ-025 SHALL place the state enum, IMG_PIXELS and the timeout digit code 4'hF in shared package cnn_ctrl_pkg.
REQ-026 SHALL instantiate one sub-module, cnn_cycle_counter (clear, enable, saturating CNT_W count).

Verification
REQ-027 Batch of 1, CNN model fc_done 1200 cycles after first beat -> 784 contiguous beats matching hex file, res_cycles=1200, res_index=0, done 1 cycle after GAP.
REQ-028 Batch of 3 -> addresses 0..2351 contiguous, res_index 0,1,2, exactly GAP idle cycles between the last beat of image 0's report and the next PRIME.
REQ-029 CNN model never asserts fc_done, TIMEOUT=100 -> res_digit=4'hF, res_timeout=1, batch continues to next image.
REQ-030 start with num_images=0 -> done next cycle, zero mem_rd_en, zero cnn_valid_in.
REQ-031 abort at pixel 400 of image 1 -> cnn_valid_in low next cycle, no further res_valid, no done, busy low, a new start then works.
REQ-032 rst_n low mid-STREAM -> all outputs 0 asynchronously; start pulse during busy ignored.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN batch inference sequencer.
// Holds the FSM state encoding, default image size and the timeout class code.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_REPORT,
    ST_GAP_WAIT
  } state_e;

  localparam int         CNN_IMG_PIXELS    = 784;
  localparam logic [3:0] CNN_TIMEOUT_DIGIT = 4'hF;

endpackage

// File: rtl/cnn_cycle_counter.sv
// Saturating cycle counter: synchronous clear wins over enable, holds at all-ones.
// Value is visible the cycle after clear/enable; no backpressure.
module cnn_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnn_infer_seq.sv
// Batch sequencer: streams each image from pixel memory into the CNN, then reports class and latency.
// Reads lead beats by one cycle; no backpressure, the CNN must take one beat per cycle.
module cnn_infer_seq
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_PIXELS = CNN_IMG_PIXELS,
  parameter int ADDR_W     = 20,
  parameter int IDX_W      = 10,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 65535,
  parameter int GAP        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  num_images,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              cnn_valid_in,
  output logic signed [7:0] cnn_data_in,
  input  logic              cnn_fc_done,
  input  logic [3:0]        cnn_final_digit,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_index,
  output logic [3:0]        res_digit,
  output logic [CNT_W-1:0]  res_cycles,
  output logic              res_timeout
);

  state_e            state_q;
  logic              busy_q, done_q, rd_en_q, valid_q, res_valid_q, res_timeout_q;
  logic [ADDR_W-1:0] addr_q, base_q, pix_q;
  logic [IDX_W-1:0]  n_img_q, img_q, res_index_q;
  logic [3:0]        res_digit_q;
  logic [CNT_W-1:0]  res_cycles_q, tmr_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic              timed_out, launch;

  cnn_cycle_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == ST_PRIME),
    .en_i    ((state_q == ST_STREAM) || (state_q == ST_WAIT_DONE)),
    .cnt_o   (lat_cnt)
  );

  // tmr_q is shared: WAIT_DONE timeout count, then GAP_WAIT idle count.
  assign timed_out = (tmr_q == CNT_W'(TIMEOUT - 1));
  assign launch    = ((state_q == ST_REPORT) && (GAP == 0)) ||
                     ((state_q == ST_GAP_WAIT) && (tmr_q == CNT_W'(GAP - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      valid_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      addr_q        <= '0;
      base_q        <= '0;
      pix_q         <= '0;
      n_img_q       <= '0;
      img_q         <= '0;
      res_index_q   <= '0;
      res_digit_q   <= '0;
      res_cycles_q  <= '0;
      tmr_q         <= '0;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        rd_en_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (num_images == '0) begin
                done_q <= 1'b1;
              end else begin
                n_img_q <= num_images;
                img_q   <= '0;
                base_q  <= '0;
                addr_q  <= '0;
                rd_en_q <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= ST_PRIME;
              end
            end
          end
          ST_PRIME: begin
            state_q <= ST_STREAM;
            valid_q <= 1'b1;
            pix_q   <= '0;
            rd_en_q <= (IMG_PIXELS > 1);
            if (IMG_PIXELS > 1) addr_q <= addr_q + ADDR_W'(1);
          end
          ST_STREAM: begin
            if (pix_q == ADDR_W'(IMG_PIXELS - 1)) begin
              valid_q <= 1'b0;
              rd_en_q <= 1'b0;
              tmr_q   <= '0;
              state_q <= ST_WAIT_DONE;
            end else begin
              pix_q   <= pix_q + ADDR_W'(1);
              rd_en_q <= (pix_q + ADDR_W'(2)) < ADDR_W'(IMG_PIXELS);
              if ((pix_q + ADDR_W'(2)) < ADDR_W'(IMG_PIXELS)) addr_q <= addr_q + ADDR_W'(1);
            end
          end
          ST_WAIT_DONE: begin
            tmr_q <= tmr_q + CNT_W'(1);
            if (cnn_fc_done || timed_out) begin
              res_valid_q   <= 1'b1;
              res_index_q   <= img_q;
              res_cycles_q  <= lat_cnt;
              res_timeout_q <= !cnn_fc_done;
              res_digit_q   <= cnn_fc_done ? cnn_final_digit : CNN_TIMEOUT_DIGIT;
              img_q         <= img_q + IDX_W'(1);
              base_q        <= base_q + ADDR_W'(IMG_PIXELS);
              state_q       <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            tmr_q <= '0;
            if (GAP != 0) state_q <= ST_GAP_WAIT;
          end
          ST_GAP_WAIT: tmr_q <= tmr_q + CNT_W'(1);
          default:     state_q <= ST_IDLE;
        endcase
        // img_q/base_q already point at the next image here.
        if (launch) begin
          if (img_q == n_img_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rd_en_q <= 1'b1;
            addr_q  <= base_q;
            state_q <= ST_PRIME;
          end
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign cnn_valid_in = valid_q;
  assign cnn_data_in  = valid_q ? $signed(mem_rd_data) : '0;
  assign res_valid    = res_valid_q;
  assign res_index    = res_index_q;
  assign res_digit    = res_digit_q;
  assign res_cycles   = res_cycles_q;
  assign res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_cnn_infer_seq.sv
// Directed bench for cnn_infer_seq with a pixel-memory model and a CNN model of programmable latency.
// 784 pixels/image, TIMEOUT=500 so the 1200-cycle latency case still completes, GAP=4.
module tb_cnn_infer_seq;

  localparam int IMG = 784;
  localparam int TMO = 500;
  localparam int GP  = 4;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [9:0]        num_images;
  logic              busy, done, mem_rd_en;
  logic [19:0]       mem_addr;
  logic [7:0]        mem_rd_data;
  logic              cnn_valid_in;
  logic signed [7:0] cnn_data_in;
  logic              fc_done;
  logic [3:0]        cnn_final_digit;
  logic              res_valid, res_timeout;
  logic [9:0]        res_index;
  logic [3:0]        res_digit;
  logic [31:0]       res_cycles;

  logic       fc_en;
  int         lat_cfg;
  logic [3:0] fc_digit;

  int n_cmp = 0;
  int n_err = 0;

  // monitor state
  int   n_rd = 0, addr_err = 0, n_beats = 0, data_err = 0, run_err = 0, zero_err = 0;
  int   n_res = 0, n_done = 0, gap_meas = -1, bi = 0, run = 0, since = 0;
  int   rd_exp = 0, b_exp = 0, cyc_n = 0, res_cyc = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0, prev_rd = 1'b0, have_res = 1'b0;

  int s_rd, s_aerr, s_beats, s_derr, s_run, s_zero, s_res, s_done;

  always #5 clk = ~clk;

  cnn_infer_seq #(
    .IMG_PIXELS (IMG),
    .ADDR_W     (20),
    .IDX_W      (10),
    .CNT_W      (32),
    .TIMEOUT    (TMO),
    .GAP        (GP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .num_images      (num_images),
    .busy            (busy),
    .done            (done),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .cnn_valid_in    (cnn_valid_in),
    .cnn_data_in     (cnn_data_in),
    .cnn_fc_done     (fc_done),
    .cnn_final_digit (cnn_final_digit),
    .res_valid       (res_valid),
    .res_index       (res_index),
    .res_digit       (res_digit),
    .res_cycles      (res_cycles),
    .res_timeout     (res_timeout)
  );

  function automatic logic [7:0] pix_of(input int a);
    return 8'((a * 37) ^ (a >>> 4));
  endfunction

  // Digit is only correct during the fc_done cycle, so a late/early latch shows up.
  assign cnn_final_digit = fc_done ? fc_digit : ~fc_digit;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pix_of(int'(mem_addr));
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
      prev_rd    = 1'b0;
      have_res   = 1'b0;
      fc_done    = 1'b0;
    end else begin
      cyc_n++;
      if (busy && !prev_busy) begin
        rd_exp   = 0;
        b_exp    = 0;
        have_res = 1'b0;
      end
      if (mem_rd_en) begin
        n_rd++;
        if (mem_addr !== 20'(rd_exp)) addr_err++;
        rd_exp++;
        if (!prev_rd && have_res) begin
          gap_meas = cyc_n - res_cyc - 1;
          have_res = 1'b0;
        end
      end
      if (cnn_valid_in) begin
        if (!prev_valid) begin
          bi  = 0;
          run = 0;
        end else begin
          bi++;
        end
        run++;
        n_beats++;
        if (cnn_data_in !== $signed(pix_of(b_exp))) data_err++;
        b_exp++;
      end else begin
        if (cnn_data_in !== 8'sd0) zero_err++;
        if (prev_valid && run != IMG) run_err++;
      end
      if (cnn_valid_in && !prev_valid) since = 0;
      else                             since++;
      fc_done = fc_en && (since == lat_cfg);
      if (res_valid) begin
        n_res++;
        res_cyc  = cyc_n;
        have_res = 1'b1;
      end
      if (done) n_done++;
      prev_valid = cnn_valid_in;
      prev_busy  = busy;
      prev_rd    = mem_rd_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [9:0] n);
    tick();
    num_images = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_res(input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (res_valid) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic snap();
    s_rd    = n_rd;
    s_aerr  = addr_err;
    s_beats = n_beats;
    s_derr  = data_err;
    s_run   = run_err;
    s_zero  = zero_err;
    s_res   = n_res;
    s_done  = n_done;
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_reads"},    32'(n_rd - s_rd),        32'(n * IMG));
    check({tag, "_addr_err"}, 32'(addr_err - s_aerr),  0);
    check({tag, "_beats"},    32'(n_beats - s_beats),  32'(n * IMG));
    check({tag, "_data_err"}, 32'(data_err - s_derr),  0);
    check({tag, "_run_err"},  32'(run_err - s_run),    0);
    check({tag, "_idle_dat"}, 32'(zero_err - s_zero),  0);
  endtask

  task automatic check_res(input string tag, input int w, input int idx, input int dig,
                           input int cyc, input int tmo);
    check({tag, "_seen"},    32'(w >= 0),        1);
    check({tag, "_index"},   32'(res_index),     32'(idx));
    check({tag, "_digit"},   32'(res_digit),     32'(dig));
    check({tag, "_cycles"},  res_cycles,         32'(cyc));
    check({tag, "_timeout"}, 32'(res_timeout),   32'(tmo));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 32'({busy, done, mem_rd_en, cnn_valid_in, res_valid, res_timeout}), 0);
    check({tag, "_addr"},  32'(mem_addr), 0);
    check({tag, "_data"},  32'($unsigned(cnn_data_in)), 0);
    check({tag, "_index"}, 32'(res_index), 0);
    check({tag, "_digit"}, 32'(res_digit), 0);
    check({tag, "_cycles"}, res_cycles, 0);
  endtask

  initial begin
    int w, k;
    logic found;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    num_images = '0;
    fc_en      = 1'b0;
    lat_cfg    = 0;
    fc_digit   = 4'd0;

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // empty batch
    snap();
    pulse_start(10'd0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    tick();
    check("zero_done_pulse", 32'(done), 0);
    repeat (5) tick();
    check("zero_reads", 32'(n_rd - s_rd), 0);
    check("zero_beats", 32'(n_beats - s_beats), 0);

    // single image, latency 1200
    fc_en    = 1'b1;
    lat_cfg  = 1200;
    fc_digit = 4'd7;
    snap();
    pulse_start(10'd1);
    wait_res(3000, w);
    check_res("b1", w, 0, 7, 1200, 0);
    wait_done(20, k);
    check("b1_done_delay", 32'(k), 32'(GP + 1));
    check("b1_busy_end", 32'(busy), 0);
    check_stream("b1", 1);
    check("b1_nres", 32'(n_res - s_res), 1);
    check("b1_ndone", 32'(n_done - s_done), 1);

    // three images: normal, fc_done during STREAM then timeout, normal; extra start ignored
    lat_cfg  = 1200;
    fc_digit = 4'd7;
    snap();
    pulse_start(10'd3);
    repeat (50) tick();
    pulse_start(10'd9);
    wait_res(3000, w);
    check_res("b3_i0", w, 0, 7, 1200, 0);
    lat_cfg  = 100;
    fc_digit = 4'd9;
    wait_res(3000, w);
    check_res("b3_i1", w, 1, 15, IMG + TMO - 1, 1);
    check("b3_gap", 32'(gap_meas), 32'(GP));
    lat_cfg  = 790;
    fc_digit = 4'd3;
    wait_res(3000, w);
    check_res("b3_i2", w, 2, 3, 790, 0);
    wait_done(20, k);
    check("b3_done_delay", 32'(k), 32'(GP + 1));
    check_stream("b3", 3);
    check("b3_nres", 32'(n_res - s_res), 3);
    check("b3_ndone", 32'(n_done - s_done), 1);
    repeat (3) tick();
    check("b3_hold_index", 32'(res_index), 2);
    check("b3_hold_digit", 32'(res_digit), 3);

    // abort at pixel 400 of image 1
    lat_cfg  = 1200;
    fc_digit = 4'd7;
    pulse_start(10'd3);
    wait_res(3000, w);
    check("ab_i0_seen", 32'(w >= 0), 1);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (cnn_valid_in && bi == 400) begin
        found = 1'b1;
        break;
      end
    end
    check("ab_pixel400_seen", 32'(found), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(cnn_valid_in), 0);
    check("ab_rd_en", 32'(mem_rd_en), 0);
    check("ab_busy", 32'(busy), 0);
    s_res  = n_res;
    s_done = n_done;
    repeat (1500) tick();
    check("ab_no_res", 32'(n_res - s_res), 0);
    check("ab_no_done", 32'(n_done - s_done), 0);
    lat_cfg  = 800;
    fc_digit = 4'd5;
    snap();
    pulse_start(10'd1);
    wait_res(3000, w);
    check_res("ab_restart", w, 0, 5, 800, 0);
    wait_done(20, k);
    check("ab_restart_done", 32'(k), 32'(GP + 1));
    check_stream("ab_restart", 1);

    // reset mid-STREAM
    lat_cfg = 1200;
    pulse_start(10'd2);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (cnn_valid_in && bi == 200) begin
        found = 1'b1;
        break;
      end
    end
    check("rs_pixel200_seen", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rs_async");
    repeat (3) tick();
    rst_n  = 1'b1;
    s_res  = n_res;
    s_done = n_done;
    repeat (1500) tick();
    check("rs_no_res", 32'(n_res - s_res), 0);
    check("rs_no_done", 32'(n_done - s_done), 0);
    check("rs_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
